fruit_spawner: RTL and testbench

FRUIT_SPAWNER -- requirements
Module: fruit_spawner

---
 rtl/fruit_spawner.sv | 160 ++++++++++++++++
 tb/tb_fruit_spawner.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fruit_spawner.sv
// Fruit placement engine: random LFSR picks first, then a row-major scan fallback.
// Reads the map through a one-cycle-latency port and emits a single write pulse per placement.
module fruit_spawner #(
  parameter int          MAPA_WIDTH  = 40,
  parameter int          MAPA_HEIGHT = 30,
  parameter int          MAX_TRIES   = 32,
  parameter logic [15:0] SEED        = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spawn_req,
  input  logic [1:0] spawn_rdata,
  output logic       spawn_renable,
  output logic [9:0] spawn_rx,
  output logic [9:0] spawn_ry,
  output logic       fruta_wenable,
  output logic [9:0] fruta_wx,
  output logic [9:0] fruta_wy,
  output logic       busy,
  output logic       map_full
);
  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int          TW       = $clog2(MAX_TRIES + 1);
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
  localparam logic [9:0]  W10  = 10'(MAPA_WIDTH);
  localparam logic [9:0]  H10  = 10'(MAPA_HEIGHT);
  localparam logic [9:0]  XMAX = 10'(MAPA_WIDTH - 1);
  localparam logic [9:0]  YMAX = 10'(MAPA_HEIGHT - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0, PICK = 3'd1, READ = 3'd2, CHECK = 3'd3,
    SCAN_READ = 3'd4, SCAN_CHECK = 3'd5, WRITE = 3'd6
  } state_t;

  state_t        state_q;
  logic [15:0]   lfsr_q, lfsr_d;
  logic [TW-1:0] tries_q;
  logic [9:0]    cand_x_q, cand_y_q, scan_x_q, scan_y_q;
  logic [9:0]    rx_q, ry_q, wx_q, wy_q;
  logic          renable_q, wen_q, full_q;
  logic [9:0]    pick_x, pick_y;
  logic          pick_ok, cell_empty, scan_last;

  // Free-running Galois LFSR, independent of the FSM.
  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^ ({16{lfsr_q[0]}} & 16'hB400);

  always_ff @(posedge clk) begin
    if (!reset) lfsr_q <= SEED_EFF;
    else        lfsr_q <= lfsr_d;
  end

  assign pick_x     = {4'b0, lfsr_q[5:0]};
  assign pick_y     = {5'b0, lfsr_q[10:6]};
  assign pick_ok    = (pick_x < W10) && (pick_y < H10);
  assign cell_empty = (spawn_rdata == 2'b00);
  assign scan_last  = (scan_x_q == XMAX) && (scan_y_q == YMAX);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      tries_q   <= '0;
      cand_x_q  <= '0;
      cand_y_q  <= '0;
      scan_x_q  <= '0;
      scan_y_q  <= '0;
      rx_q      <= '0;
      ry_q      <= '0;
      wx_q      <= '0;
      wy_q      <= '0;
      renable_q <= 1'b0;
      wen_q     <= 1'b0;
      full_q    <= 1'b0;
    end else begin
      renable_q <= 1'b0;
      wen_q     <= 1'b0;
      unique case (state_q)
        IDLE: if (spawn_req) begin
          tries_q <= '0;
          full_q  <= 1'b0;
          state_q <= PICK;
        end
        PICK: begin
          if (pick_ok) begin
            cand_x_q  <= pick_x;
            cand_y_q  <= pick_y;
            rx_q      <= pick_x;
            ry_q      <= pick_y;
            renable_q <= 1'b1;
            state_q   <= READ;
          end else if (tries_q == TRY_LAST) begin
            scan_x_q  <= '0;
            scan_y_q  <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            renable_q <= 1'b1;
            state_q   <= SCAN_READ;
          end else begin
            tries_q <= tries_q + TW'(1);
          end
        end
        READ: state_q <= CHECK;
        CHECK: begin
          if (cell_empty) begin
            wen_q   <= 1'b1;
            wx_q    <= cand_x_q;
            wy_q    <= cand_y_q;
            state_q <= WRITE;
          end else if (tries_q == TRY_LAST) begin
            scan_x_q  <= '0;
            scan_y_q  <= '0;
            rx_q      <= '0;
            ry_q      <= '0;
            renable_q <= 1'b1;
            state_q   <= SCAN_READ;
          end else begin
            tries_q <= tries_q + TW'(1);
            state_q <= PICK;
          end
        end
        SCAN_READ: state_q <= SCAN_CHECK;
        SCAN_CHECK: begin
          if (cell_empty) begin
            wen_q   <= 1'b1;
            wx_q    <= scan_x_q;
            wy_q    <= scan_y_q;
            state_q <= WRITE;
          end else if (scan_last) begin
            full_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            // Row-major advance; the read strobe for the next cell goes out immediately.
            if (scan_x_q == XMAX) begin
              scan_x_q <= '0;
              scan_y_q <= scan_y_q + 10'd1;
              rx_q     <= '0;
              ry_q     <= scan_y_q + 10'd1;
            end else begin
              scan_x_q <= scan_x_q + 10'd1;
              rx_q     <= scan_x_q + 10'd1;
              ry_q     <= scan_y_q;
            end
            renable_q <= 1'b1;
            state_q   <= SCAN_READ;
          end
        end
        WRITE:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy          = (state_q != IDLE);
  assign spawn_renable = renable_q;
  assign spawn_rx      = rx_q;
  assign spawn_ry      = ry_q;
  assign fruta_wenable = wen_q;
  assign fruta_wx      = wx_q;
  assign fruta_wy      = wy_q;
  assign map_full      = full_q;
endmodule

// File: tb/tb_fruit_spawner.sv
// Directed bench for fruit_spawner with a 40x30 behavioural map model.
module tb_fruit_spawner;
  logic       clk = 1'b0;
  logic       reset, spawn_req;
  logic [1:0] spawn_rdata;
  logic       spawn_renable, fruta_wenable, busy, map_full;
  logic [9:0] spawn_rx, spawn_ry, fruta_wx, fruta_wy;

  int n_chk = 0, n_err = 0, n_place = 0;
  logic [1:0] mapm [40][30];

  localparam int S_READ = 2, S_CHECK = 3, S_SREAD = 4;

  fruit_spawner dut (
    .clk(clk), .reset(reset), .spawn_req(spawn_req), .spawn_rdata(spawn_rdata),
    .spawn_renable(spawn_renable), .spawn_rx(spawn_rx), .spawn_ry(spawn_ry),
    .fruta_wenable(fruta_wenable), .fruta_wx(fruta_wx), .fruta_wy(fruta_wy),
    .busy(busy), .map_full(map_full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Map read port: data one cycle after the strobe.
  always @(posedge clk)
    if (spawn_renable && spawn_rx < 10'd40 && spawn_ry < 10'd30)
      spawn_rdata <= mapm[spawn_rx[5:0]][spawn_ry[4:0]];
    else
      spawn_rdata <= 2'b11;

  always @(negedge clk) begin
    if (spawn_renable) begin
      chk("rd_state", 32'(int'(dut.state_q) == S_READ || int'(dut.state_q) == S_SREAD), 1);
      chk("rd_range", 32'(spawn_rx < 10'd40 && spawn_ry < 10'd30), 1);
    end
    if (fruta_wenable) begin
      n_place++;
      chk("wr_range", 32'(fruta_wx < 10'd40 && fruta_wy < 10'd30), 1);
    end
  end

  task automatic fill(input logic [1:0] v);
    for (int x = 0; x < 40; x++)
      for (int y = 0; y < 30; y++) mapm[x][y] = v;
  endtask

  task automatic pulse_req();
    @(negedge clk) spawn_req = 1'b1;
    @(negedge clk) spawn_req = 1'b0;
  endtask

  task automatic wait_place(input int bound, output int cyc);
    cyc = 0;
    while (!fruta_wenable && cyc < bound) begin
      @(negedge clk);
      cyc++;
    end
    if (!fruta_wenable) chk("place_timeout", 0, 1);
  endtask

  task automatic wait_idle(input int bound);
    int c = 0;
    while (busy && c < bound) begin
      @(negedge clk);
      c++;
    end
    chk("idle_timeout", 32'(busy), 0);
  endtask

  initial begin
    int lat, p0;
    reset = 1'b0; spawn_req = 1'b0;
    fill(2'b00);
    repeat (3) @(negedge clk);
    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ren", 32'(spawn_renable), 0);
    chk("rst_rx", 32'(spawn_rx), 0);
    chk("rst_wen", 32'(fruta_wenable), 0);
    chk("rst_wx", 32'(fruta_wx), 0);
    chk("rst_wy", 32'(fruta_wy), 0);
    chk("rst_full", 32'(map_full), 0);
    chk("rst_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    reset = 1'b1;
    @(negedge clk);

    // Empty map: random path places quickly on an empty cell
    p0 = n_place;
    pulse_req();
    chk("t2_busy", 32'(busy), 1);
    wait_place(200, lat);
    chk("t2_lat", 32'(lat + 1 >= 4 && lat + 1 <= 4 + 3 * 32), 1);
    chk("t2_cell", 32'(mapm[fruta_wx[5:0]][fruta_wy[4:0]]), 0);
    mapm[fruta_wx[5:0]][fruta_wy[4:0]] = 2'b10;
    repeat (3) @(negedge clk);
    chk("t2_count", 32'(n_place - p0), 1);
    chk("t2_idle", 32'(busy), 0);

    // Only (39,29) empty: scan fallback finds it
    fill(2'b01); mapm[39][29] = 2'b00;
    pulse_req();
    wait_place(2600, lat);
    chk("t3_lat", 32'(lat + 1 <= 32 * 3 + 2400 + 4), 1);
    chk("t3_wx", 32'(fruta_wx), 39);
    chk("t3_wy", 32'(fruta_wy), 29);
    @(negedge clk);
    chk("t3_full", 32'(map_full), 0);

    // All obstacles: map_full, no write, coordinates held
    fill(2'b11);
    p0 = n_place;
    pulse_req();
    wait_idle(2700);
    chk("t4_full", 32'(map_full), 1);
    chk("t4_nowr", 32'(n_place - p0), 0);
    chk("t4_wx", 32'(fruta_wx), 39);
    chk("t4_wy", 32'(fruta_wy), 29);
    repeat (2) @(negedge clk);
    chk("t4_sticky", 32'(map_full), 1);

    // Next accepted request clears map_full
    fill(2'b00);
    pulse_req();
    chk("t5_clr", 32'(map_full), 0);
    wait_place(200, lat);
    chk("t5_cell", 32'(mapm[fruta_wx[5:0]][fruta_wy[4:0]]), 0);
    repeat (2) @(negedge clk);

    // Request held 10 cycles during a long search: one placement
    fill(2'b01); mapm[39][29] = 2'b00;
    p0 = n_place;
    @(negedge clk) spawn_req = 1'b1;
    repeat (10) @(negedge clk);
    spawn_req = 1'b0;
    wait_place(2600, lat);
    chk("t6_wx", 32'(fruta_wx), 39);
    chk("t6_wy", 32'(fruta_wy), 29);
    repeat (5) @(negedge clk);
    chk("t6_count", 32'(n_place - p0), 1);
    chk("t6_idle", 32'(busy), 0);

    // Request still high after WRITE: re-enters after one IDLE cycle
    fill(2'b00);
    p0 = n_place;
    @(negedge clk) spawn_req = 1'b1;
    wait_place(200, lat);
    @(negedge clk);
    chk("t7_idle", 32'(busy), 0);
    @(negedge clk);
    chk("t7_reenter", 32'(busy), 1);
    spawn_req = 1'b0;
    wait_place(200, lat);
    repeat (3) @(negedge clk);
    chk("t7_count", 32'(n_place - p0), 2);

    // Reset while in CHECK aborts the placement
    fill(2'b00);
    p0 = n_place;
    pulse_req();
    lat = 0;
    while (int'(dut.state_q) != S_CHECK && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    chk("t8_incheck", 32'(int'(dut.state_q)), S_CHECK);
    reset = 1'b0;
    @(negedge clk);
    chk("t8_state", 32'(int'(dut.state_q)), 0);
    chk("t8_busy", 32'(busy), 0);
    chk("t8_wen", 32'(fruta_wenable), 0);
    chk("t8_lfsr", 32'(dut.lfsr_q), 32'hACE1);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    chk("t8_nowr", 32'(n_place - p0), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
